// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a per-register busy
// scoreboard. Asynchronous reads, synchronous writes, x0 hardwired to zero.
// Optional build macro REGFILE_BYPASS_EN: write-first forwarding of
// same-cycle writes (data and busy-clear) onto the read ports.

// Single read port: storage lookup, optional forwarding, x0 masking.
module regfile_mp_rport #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NWRITE = 2,
  parameter int AW     = $clog2(NREG)
) (
  input  logic [NREG-1:0][XLEN-1:0] rf,
  input  logic [NREG-1:0]           busy,
  input  logic [AW-1:0]             ra,
`ifdef REGFILE_BYPASS_EN
  input  logic [NWRITE-1:0]         we,
  input  logic [NWRITE*AW-1:0]      wa,
  input  logic [NWRITE*XLEN-1:0]    wd,
  input  logic [NWRITE-1:0]         wclr,
`endif
  output logic [XLEN-1:0]           rd,
  output logic                      rbusy
);

  // Lookup, then later write ports override earlier ones, then x0 forces zero
  always_comb begin
    rd    = rf[ra];
    rbusy = busy[ra];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NWRITE; j++) begin
      if (we[j] && (wa[j*AW +: AW] == ra)) begin
        rd = wd[j*XLEN +: XLEN];
        if (wclr[j]) rbusy = 1'b0;
      end
    end
`endif
    if (ra == '0) begin
      rd    = '0;
      rbusy = 1'b0;
    end
  end

endmodule

module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREAD*AW-1:0]     ra,
  output logic [NREAD*XLEN-1:0]   rd,
  output logic [NREAD-1:0]        rbusy,
  input  logic [NWRITE-1:0]       we,
  input  logic [NWRITE*AW-1:0]    wa,
  input  logic [NWRITE*XLEN-1:0]  wd,
  input  logic [NWRITE-1:0]       wclr,
  input  logic                    issue_en,
  input  logic [AW-1:0]           issue_rd,
  output logic [NREG-1:0]         busy_vec
);

  logic [NREG-1:0][XLEN-1:0] rf;
  logic [NREG-1:0]           busy, busy_nxt;

  // Register writes; loop order gives the higher-index port priority on collisions
  always_ff @(posedge clk) begin
    if (reset) begin
      rf <= '0;
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (we[j] && (wa[j*AW +: AW] != '0))
          rf[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
      end
    end
  end

  // Scoreboard next state: writeback clears first, then issue sets (new producer wins)
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWRITE; j++) begin
      if (we[j] && wclr[j]) busy_nxt[wa[j*AW +: AW]] = 1'b0;
    end
    if (issue_en && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  assign busy_vec = busy;

  for (genvar i = 0; i < NREAD; i++) begin : g_rport
    regfile_mp_rport #(
      .XLEN(XLEN), .NREG(NREG), .NWRITE(NWRITE), .AW(AW)
    ) u_rport (
      .rf    (rf),
      .busy  (busy),
      .ra    (ra[i*AW +: AW]),
`ifdef REGFILE_BYPASS_EN
      .we    (we),
      .wa    (wa),
      .wd    (wd),
      .wclr  (wclr),
`endif
      .rd    (rd[i*XLEN +: XLEN]),
      .rbusy (rbusy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table-driven checks of regfile_mp (default params),
// plus hand sequences for mid-operation reset and same-cycle forwarding.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic [1:0]  wclr;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [31:0] busy_vec;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .wclr(wclr),
    .issue_en(issue_en), .issue_rd(issue_rd), .busy_vec(busy_vec)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [1:0]  wclr;
    logic        ie;
    logic [4:0]  ird;
    logic [4:0]  ra0, ra1;
    logic [31:0] e_rd0, e_rd1;
    logic [1:0]  e_rb;
    logic [31:0] e_bv;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rst, logic [1:0] w, logic [4:0] a0, logic [4:0] a1,
                              logic [31:0] d0, logic [31:0] d1, logic [1:0] cl,
                              logic ie, logic [4:0] ird, logic [4:0] r0, logic [4:0] r1,
                              logic [31:0] x0, logic [31:0] x1, logic [1:0] xb,
                              logic [31:0] xbv);
    vec_t v;
    v.rst = rst; v.we = w; v.wa0 = a0; v.wa1 = a1; v.wd0 = d0; v.wd1 = d1;
    v.wclr = cl; v.ie = ie; v.ird = ird; v.ra0 = r0; v.ra1 = r1;
    v.e_rd0 = x0; v.e_rd1 = x1; v.e_rb = xb; v.e_bv = xbv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle();
    reset = 1'b0; we = '0; wclr = '0; issue_en = 1'b0;
  endtask

  // Apply one vector across an edge, then drop writes/issue so the
  // sampled outputs are post-edge state in any build.
  task automatic step(input vec_t v);
    @(negedge clk);
    reset = v.rst; we = v.we; wa = {v.wa1, v.wa0}; wd = {v.wd1, v.wd0};
    wclr = v.wclr; issue_en = v.ie; issue_rd = v.ird; ra = {v.ra1, v.ra0};
    @(posedge clk);
    #1 idle();
    #1;
  endtask

  function automatic vec_t op(logic rst, logic [1:0] w, logic [4:0] a0, logic [4:0] a1,
                              logic [31:0] d0, logic [31:0] d1, logic [1:0] cl,
                              logic ie, logic [4:0] ird, logic [4:0] r0, logic [4:0] r1);
    return mk(rst, w, a0, a1, d0, d1, cl, ie, ird, r0, r1, '0, '0, '0, '0);
  endfunction

  initial begin
    idle(); ra = '0; wa = '0; wd = '0; issue_rd = '0;

    //         rst we  wa0 wa1 wd0           wd1           wclr ie ird ra0 ra1 e_rd0         e_rd1         e_rb  e_bv
    vt.push_back(mk(1, 2'b11, 5, 6, 32'h11, 32'h22, 2'b11, 1, 9, 5, 31, 32'h0, 32'h0, 2'b00, 32'h0));
    vt.push_back(mk(0, 2'b01, 5, 0, 32'hDEADBEEF, 32'h0, 2'b00, 0, 0, 5, 0, 32'hDEADBEEF, 32'h0, 2'b00, 32'h0));
    vt.push_back(mk(0, 2'b01, 0, 0, 32'h12345678, 32'h0, 2'b00, 0, 0, 0, 5, 32'h0, 32'hDEADBEEF, 2'b00, 32'h0));
    vt.push_back(mk(0, 2'b11, 7, 7, 32'h1111, 32'h2222, 2'b00, 0, 0, 7, 5, 32'h2222, 32'hDEADBEEF, 2'b00, 32'h0));
    vt.push_back(mk(0, 2'b00, 0, 0, 32'h0, 32'h0, 2'b00, 1, 9, 9, 0, 32'h0, 32'h0, 2'b01, 32'h200));
    vt.push_back(mk(0, 2'b01, 9, 0, 32'hAAAA, 32'h0, 2'b01, 1, 9, 9, 7, 32'hAAAA, 32'h2222, 2'b01, 32'h200));
    vt.push_back(mk(0, 2'b01, 9, 0, 32'hBBBB, 32'h0, 2'b01, 0, 0, 9, 0, 32'hBBBB, 32'h0, 2'b00, 32'h0));
    vt.push_back(mk(0, 2'b01, 0, 0, 32'h99, 32'h0, 2'b01, 1, 0, 0, 9, 32'h0, 32'hBBBB, 2'b00, 32'h0));
    vt.push_back(mk(0, 2'b00, 0, 0, 32'h0, 32'h0, 2'b00, 1, 12, 12, 9, 32'h0, 32'hBBBB, 2'b01, 32'h1000));
    vt.push_back(mk(0, 2'b10, 0, 12, 32'h0, 32'h5, 2'b00, 0, 0, 12, 0, 32'h5, 32'h0, 2'b01, 32'h1000));
    vt.push_back(mk(0, 2'b00, 12, 12, 32'h0, 32'h0, 2'b11, 0, 0, 12, 0, 32'h5, 32'h0, 2'b01, 32'h1000));
    vt.push_back(mk(0, 2'b10, 0, 12, 32'h0, 32'h6, 2'b10, 0, 0, 0, 12, 32'h0, 32'h6, 2'b00, 32'h0));
    vt.push_back(mk(0, 2'b00, 0, 0, 32'h0, 32'h0, 2'b00, 1, 12, 12, 0, 32'h6, 32'h0, 2'b01, 32'h1000));
    vt.push_back(mk(0, 2'b00, 0, 0, 32'h0, 32'h0, 2'b00, 1, 12, 12, 0, 32'h6, 32'h0, 2'b01, 32'h1000));
    vt.push_back(mk(0, 2'b10, 0, 12, 32'h0, 32'h6, 2'b10, 0, 0, 0, 12, 32'h0, 32'h6, 2'b00, 32'h0));

    for (int k = 0; k < vt.size(); k++) begin
      step(vt[k]);
      chk($sformatf("v%0d rd0", k), rd[31:0], vt[k].e_rd0);
      chk($sformatf("v%0d rd1", k), rd[63:32], vt[k].e_rd1);
      chk($sformatf("v%0d rbusy", k), {30'b0, rbusy}, {30'b0, vt[k].e_rb});
      chk($sformatf("v%0d busy_vec", k), busy_vec, vt[k].e_bv);
    end

    // Mid-operation reset: regs 1..4 busy, reg 2 written, then reset with a write pending
    for (int r = 1; r <= 4; r++) step(op(0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 5'(r), 0, 0));
    step(op(0, 2'b01, 2, 0, 32'hFFFFFFFF, 0, 2'b00, 0, 0, 2, 4));
    chk("pre-reset busy_vec", busy_vec, 32'h1E);
    chk("pre-reset rd2", rd[31:0], 32'hFFFFFFFF);
    chk("pre-reset rbusy", {30'b0, rbusy}, 32'h3);
    step(op(1, 2'b11, 3, 7, 32'h77, 32'h88, 2'b00, 1, 6, 2, 3));
    chk("mid-reset busy_vec", busy_vec, 32'h0);
    chk("mid-reset rd2", rd[31:0], 32'h0);
    chk("mid-reset rd3 dropped", rd[63:32], 32'h0);
    ra = {5'd6, 5'd7};
    #1 chk("mid-reset rd7 dropped", rd[31:0], 32'h0);

    // Same-cycle forwarding of a clearing writeback on port 1
    step(op(0, 2'b01, 3, 0, 32'h11, 0, 2'b00, 1, 3, 3, 0));
    chk("fwd setup rd", rd[31:0], 32'h11);
    chk("fwd setup busy", busy_vec, 32'h8);
    @(negedge clk);
    we = 2'b10; wa = {5'd3, 5'd0}; wd = {32'hCAFEF00D, 32'h0}; wclr = 2'b10; ra = {5'd0, 5'd3};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("fwd same-cycle rd", rd[31:0], 32'hCAFEF00D);
    chk("fwd same-cycle rbusy", {31'b0, rbusy[0]}, 32'h0);
`else
    chk("fwd same-cycle rd", rd[31:0], 32'h11);
    chk("fwd same-cycle rbusy", {31'b0, rbusy[0]}, 32'h1);
`endif
    @(posedge clk);
    #1 idle();
    #1;
    chk("fwd next-cycle rd", rd[31:0], 32'hCAFEF00D);
    chk("fwd next-cycle rbusy", {31'b0, rbusy[0]}, 32'h0);
    chk("fwd next-cycle busy_vec", busy_vec, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined RV32I core and its wider variants.
- Provides NREAD asynchronous read ports, NWRITE synchronous write ports and a per-register busy scoreboard.
- Scoreboard bits are set at issue and cleared at writeback so the hazard unit can stall on pending producers.
- x0 is hardwired to zero and is never busy.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (power of 2, >=2); AW = $clog2(NREG)
NREAD, 2, number of read ports (1..4)
NWRITE, 2, number of write ports (1..2); higher index has priority

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
ra  in  NREAD*AW  read addresses, port i at [i*AW +: AW]
rd  out  NREAD*XLEN  read data, port i at [i*XLEN +: XLEN]
rbusy  out  NREAD  scoreboard busy bit of the register addressed by ra[i]
we  in  NWRITE  write enables
wa  in  NWRITE*AW  write addresses
wd  in  NWRITE*XLEN  write data
wclr  in  NWRITE  clear busy bit of wa[j] when we[j]=1 (writeback completion)
issue_en  in  1  mark register issue_rd as busy
issue_rd  in  AW  destination register of the issuing instruction
busy_vec  out  NREG  full scoreboard, bit k = register k busy

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: on posedge clk with reset=1, all registers become 0 and all busy bits become 0. All write and issue inputs are ignored that cycle. Afterwards rd=0, rbusy=0 and busy_vec=0 for every address. Asserting reset mid-operation discards any in-flight writes and busy state.
- Reads are combinational, 0-cycle latency: rd[i] = rf[ra[i]].
- ra[i]=0 forces rd[i]=0 and rbusy[i]=0 regardless of storage.
- Writes occur on posedge clk when we[j]=1 and wa[j]!=0.
  - Writes to address 0 are dropped and leave the x0 busy bit at 0.
- Write collision: if we[0] and we[1] target the same nonzero address in one cycle, port 1's data is stored.
- Scoreboard update on posedge, in this order:
  - clear busy[wa[j]] for each j with we[j]&wclr[j];
  - then set busy[issue_rd] if issue_en and issue_rd!=0.
  - Same-cycle clear and set of the same register leaves it busy: the new producer wins.
- wclr with we=0 has no effect.
- A write with wclr=0 updates data but leaves the busy bit unchanged, for partial or speculative writes.
- issue_en to an already busy register keeps it busy, with no counting. One clear releases it.
- busy_vec[0] is always 0.
- Out-of-range addresses cannot occur: NREG is a power of 2.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-first forwarding. If we[j]=1, wa[j]=ra[i] and ra[i]!=0 in the current cycle, rd[i] returns wd[j] combinationally, port 1 over port 0.
  - If that write also has wclr[j]=1, rbusy[i] reads 0 in the same cycle.
- Undefined: rd[i] and rbusy[i] show pre-edge state. The new value is visible the cycle after the edge, and the pipeline must stall one extra cycle.

Test Plan:
1. Reset then read: reset=1 one cycle -> all rd=0x00000000, busy_vec=0 for ra in {0,5,31}.
2. Basic write/read: we[0]=1, wa[0]=5, wd[0]=0xDEADBEEF; next cycle ra[0]=5 -> rd[0]=0xDEADBEEF. Write wa=0, wd=0x12345678 -> ra=0 reads 0.
3. Port collision: we=2'b11, wa[0]=wa[1]=7, wd[0]=0x1111, wd[1]=0x2222 -> next cycle rf[7] reads 0x00002222.
4. Scoreboard:
   - issue_en=1, issue_rd=9 -> busy_vec[9]=1 next cycle.
   - Later: we[0]=1, wa[0]=9, wclr[0]=1 in the same cycle as issue_en=1, issue_rd=9 -> busy_vec[9] stays 1.
   - A following lone clear -> busy_vec[9]=0.
5. Bypass:
   - With REGFILE_BYPASS_EN: we[1]=1, wa[1]=3, wd[1]=0xCAFEF00D, ra[0]=3 -> rd[0]=0xCAFEF00D in the same cycle.
   - Without the macro: rd[0] shows the old value, and 0xCAFEF00D appears the next cycle.
6. Reset mid-operation: issue regs 1..4 busy and write 0xFFFFFFFF to reg 2, then reset -> busy_vec=0 and rf[2]=0. A write presented during the reset cycle is not stored.
